// File: rtl/host_mem_bfm.sv
// Cycle-accurate host-memory responder for processor benches: serves single-line
// reads/writes and multi-line accelerator bursts from per-region line memories.
module host_mem_bfm #(
  parameter int LINE_W       = 512,
  parameter int DEPTH        = 128,
  parameter int REGIONS      = 4,
  parameter int RD_LAT       = 10,
  parameter int WR_LAT       = 1,
  parameter int ACCEL_REGION = 1,
  parameter int ACCEL_BURST  = 128,
  parameter int GAP          = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic [31:0]       io_addr,
  input  logic [LINE_W-1:0] wr_line,
  output logic [LINE_W-1:0] rd_line,
  output logic              tx_done,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic [15:0]       beats_done
);

  localparam int LW    = $clog2(DEPTH);
  localparam int RB    = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam int WORDS = LINE_W / 32;

  localparam logic [15:0] RD_W0  = 16'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [15:0] WR_W0  = 16'((WR_LAT > 1) ? WR_LAT - 2 : 0);
  localparam logic [15:0] GAP_W0 = 16'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [15:0] BURST  = 16'(ACCEL_BURST);
  localparam logic [4:0]  NREG   = 5'(REGIONS);
  localparam logic [3:0]  AREG   = 4'(ACCEL_REGION);

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b11;
  localparam logic [1:0] OP_RSV = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_XFER, RD_VALID, WR_WAIT, WR_XFER, WR_GAP, BEAT_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [RB-1:0]       region_q, region_d;
  logic [LW-1:0]       line_q, line_d;
  logic [15:0]         beats_q, beats_d;
  logic [15:0]         wait_q, wait_d;
  logic                aerr_q, aerr_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;
  logic                tx_done_q, tx_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [15:0]         beats_done_q, beats_done_d;
  logic                mem_we;

  // Lines never written read back the ascending reset pattern; clearing the
  // dirty map on reset restores every region in a single cycle.
  logic [REGIONS-1:0][DEPTH-1:0] dirty_q, dirty_d;
  logic [LINE_W-1:0]             mem_q [REGIONS][DEPTH];

  logic unused_addr;
  assign unused_addr = ^io_addr[27:6+LW];

  function automatic logic [LINE_W-1:0] init_line(input logic [LW-1:0] n);
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < WORDS; k++) v[k*32 +: 32] = 32'(int'(n) * WORDS + k);
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    line_d       = line_q;
    beats_d      = beats_q;
    wait_d       = wait_q;
    aerr_d       = aerr_q;
    err_d        = err_q;
    beats_done_d = beats_done_q;
    rd_line_d    = rd_line_q;
    dirty_d      = dirty_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (op == OP_RD || op == OP_WR) begin
          region_d = io_addr[28 +: RB];
          line_d   = io_addr[6 +: LW];
          aerr_d   = ({1'b0, io_addr[31:28]} >= NREG) || (io_addr[5:0] != 6'd0);
          err_d    = err_q | aerr_d;
          beats_d  = (io_addr[31:28] == AREG) ? BURST : 16'd1;
          if (op == OP_RD) begin
            state_d = (RD_LAT > 1) ? RD_WAIT : RD_XFER;
            wait_d  = RD_W0;
          end else begin
            state_d = (WR_LAT > 1) ? WR_WAIT : WR_XFER;
            wait_d  = WR_W0;
          end
        end else if (op == OP_RSV) begin
          err_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (wait_q == 16'd0) state_d = RD_XFER;
        else                 wait_d  = wait_q - 16'd1;
      end
      RD_XFER: begin
        state_d      = RD_VALID;
        beats_d      = beats_q - 16'd1;
        beats_done_d = beats_done_q + 16'd1;
      end
      RD_VALID: begin
        if (beats_q != 16'd0) begin
          line_d = line_q + LW'(1);
          if (GAP == 0) state_d = RD_XFER;
          else begin
            state_d = BEAT_GAP;
            wait_d  = GAP_W0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BEAT_GAP: begin
        if (wait_q == 16'd0) state_d = RD_XFER;
        else                 wait_d  = wait_q - 16'd1;
      end
      WR_WAIT: begin
        if (wait_q == 16'd0) state_d = WR_XFER;
        else                 wait_d  = wait_q - 16'd1;
      end
      WR_XFER: begin
        // Bad addresses still burn their beats so the processor never stalls.
        if (!aerr_q) begin
          mem_we                      = 1'b1;
          dirty_d[region_q][line_q]   = 1'b1;
        end
        beats_d      = beats_q - 16'd1;
        beats_done_d = beats_done_q + 16'd1;
        if (beats_q != 16'd1) begin
          state_d = WR_GAP;
          line_d  = line_q + LW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WR_GAP:  state_d = WR_XFER;
      default: state_d = IDLE;
    endcase

    tx_done_d  = (state_d == RD_XFER) || (state_d == WR_XFER);
    rd_valid_d = (state_d == RD_VALID);
    busy_d     = (state_d != IDLE);
    if (state_d == RD_XFER) begin
      if (aerr_d)                        rd_line_d = '0;
      else if (dirty_q[region_d][line_d]) rd_line_d = mem_q[region_d][line_d];
      else                               rd_line_d = init_line(line_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      region_q     <= '0;
      line_q       <= '0;
      beats_q      <= '0;
      wait_q       <= '0;
      aerr_q       <= 1'b0;
      rd_line_q    <= '0;
      tx_done_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      beats_done_q <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      line_q       <= line_d;
      beats_q      <= beats_d;
      wait_q       <= wait_d;
      aerr_q       <= aerr_d;
      rd_line_q    <= rd_line_d;
      tx_done_q    <= tx_done_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      beats_done_q <= beats_done_d;
      dirty_q      <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[region_q][line_q] <= wr_line;
  end

  assign rd_line    = rd_line_q;
  assign tx_done    = tx_done_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign beats_done = beats_done_q;

endmodule

// File: tb/tb_host_mem_bfm.sv
// Bench for host_mem_bfm: two instances (default and short-burst/gapped) driven
// by directed and random transactions against a line-level memory model.
module tb_host_mem_bfm;

  localparam int LINE_W = 512;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        op_s [2];
  logic [31:0]       io_addr = '0;
  logic [LINE_W-1:0] wr_line = '0;
  logic [LINE_W-1:0] rd_s [2];
  logic              tx_s [2];
  logic              rv_s [2];
  logic              busy_s [2];
  logic              err_s [2];
  logic [15:0]       bd_s [2];

  // Timing parameters of each instance, as seen by the model.
  int rd_lat_p [2] = '{10, 1};
  int wr_lat_p [2] = '{1, 3};
  int burst_p  [2] = '{128, 2};
  int gap_p    [2] = '{0, 2};

  logic [LINE_W-1:0] mdl [2][4][DEPTH];
  int                bd_m [2];
  bit                err_m [2];
  int                n_tests = 0;
  int                n_fail  = 0;

  always #5 clk = ~clk;

  host_mem_bfm u_a (
    .clk(clk), .rst(rst), .op(op_s[0]), .io_addr(io_addr), .wr_line(wr_line),
    .rd_line(rd_s[0]), .tx_done(tx_s[0]), .rd_valid(rv_s[0]), .busy(busy_s[0]),
    .err(err_s[0]), .beats_done(bd_s[0])
  );

  host_mem_bfm #(.RD_LAT(1), .WR_LAT(3), .ACCEL_BURST(2), .GAP(2)) u_b (
    .clk(clk), .rst(rst), .op(op_s[1]), .io_addr(io_addr), .wr_line(wr_line),
    .rd_line(rd_s[1]), .tx_done(tx_s[1]), .rd_valid(rv_s[1]), .busy(busy_s[1]),
    .err(err_s[1]), .beats_done(bd_s[1])
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 4; r++)
        for (int n = 0; n < DEPTH; n++)
          for (int k = 0; k < LINE_W/32; k++)
            mdl[i][r][n][k*32 +: 32] = 32'(n * 16 + k);
    bd_m  = '{0, 0};
    err_m = '{0, 0};
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk_idle_zero(input int i, input string tag);
    chk($sformatf("%s_tx%0d", tag, i), tx_s[i], 1'b0);
    chk($sformatf("%s_rv%0d", tag, i), rv_s[i], 1'b0);
    chk($sformatf("%s_busy%0d", tag, i), busy_s[i], 1'b0);
    chk($sformatf("%s_err%0d", tag, i), err_s[i], 1'b0);
    chk($sformatf("%s_bd%0d", tag, i), bd_s[i], 16'd0);
    chk($sformatf("%s_rd%0d", tag, i), rd_s[i], '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_s[0] = 2'b00; op_s[1] = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) chk_idle_zero(i, "reset");
  endtask

  // One complete transaction; every cycle is checked against the schedule
  // implied by latency, burst length and gap.
  task automatic do_txn(input int inst, input bit wr, input logic [31:0] addr, input bit fixed);
    int rg, ln, nb, lat, per, endc, d, j, ph;
    bit aerr, etx, erv;
    logic [LINE_W-1:0] wd [$];
    logic [LINE_W-1:0] tmp, last_l;
    rg   = int'(addr[31:28]);
    ln   = int'(addr[12:6]);
    aerr = (rg >= 4) || (addr[5:0] != 6'd0);
    nb   = (rg == 1) ? burst_p[inst] : 1;
    lat  = wr ? wr_lat_p[inst] : rd_lat_p[inst];
    per  = wr ? 2 : 2 + gap_p[inst];
    endc = wr ? lat - 1 + 2 * (nb - 1) : lat - 1 + (nb - 1) * per + 1;
    for (int b = 0; b < nb; b++) begin
      if (fixed) for (int k = 0; k < LINE_W/32; k++) tmp[k*32 +: 32] = 32'hA0 + 32'(k);
      else tmp = rand_line();
      wd.push_back(tmp);
    end
    last_l = '0;
    @(negedge clk);
    op_s[inst] = wr ? 2'b11 : 2'b01;
    io_addr    = addr;
    wr_line    = wd[0];
    for (int c = 0; c <= endc + 1; c++) begin
      @(negedge clk);
      if (c == 0) op_s[inst] = 2'b00;
      d = c - (lat - 1);
      j = (d >= 0) ? d / per : -1;
      ph = (d >= 0) ? d % per : -1;
      etx = (d >= 0) && (j < nb) && (ph == 0);
      erv = !wr && (d >= 0) && (j < nb) && (ph == 1);
      chk($sformatf("tx%0d_c%0d", inst, c), tx_s[inst], etx);
      chk($sformatf("rv%0d_c%0d", inst, c), rv_s[inst], erv);
      chk($sformatf("busy%0d_c%0d", inst, c), busy_s[inst], c <= endc);
      if (!wr && (etx || erv)) begin
        last_l = aerr ? '0 : mdl[inst][rg][(ln + j) % DEPTH];
        chk($sformatf("rd%0d_beat%0d", inst, j), rd_s[inst], last_l);
      end
      if (wr && d >= 0 && ph == 1 && j + 1 < nb) wr_line = wd[j + 1];
    end
    if (wr && !aerr)
      for (int b = 0; b < nb; b++) mdl[inst][rg][(ln + b) % DEPTH] = wd[b];
    if (!wr) chk($sformatf("rd_hold%0d", inst), rd_s[inst], last_l);
    bd_m[inst]  += nb;
    err_m[inst] |= aerr;
    chk($sformatf("beats_done%0d", inst), bd_s[inst], 16'(bd_m[inst]));
    chk($sformatf("err%0d", inst), err_s[inst], err_m[inst]);
  endtask

  initial begin
    int seen, inst, rg, ln;
    bit hit, wr;
    logic [31:0] addr;
    op_s[0] = 2'b00;
    op_s[1] = 2'b00;

    do_reset();

    // Instruction fetch of line 0.
    do_txn(0, 1'b0, 32'h0000_0000, 1'b0);
    chk("fetch_w0", rd_s[0][31:0], 32'd0);
    chk("fetch_w15", rd_s[0][511:480], 32'd15);

    // Data write then read back.
    do_txn(0, 1'b1, 32'h2000_0040, 1'b1);
    do_txn(0, 1'b0, 32'h2000_0040, 1'b0);
    chk("wr_rd_w0", rd_s[0][31:0], 32'hA0);
    chk("wr_rd_w15", rd_s[0][511:480], 32'hAF);

    // Full accelerator read burst.
    do_txn(0, 1'b0, 32'h1000_0000, 1'b0);

    // Two-beat write wrapping from line 127 to 0, then read back.
    do_txn(1, 1'b1, 32'h1000_1FC0, 1'b0);
    do_txn(1, 1'b0, 32'h1000_1FC0, 1'b0);

    // Reserved op: sticky err, no transaction.
    @(negedge clk); op_s[0] = 2'b10;
    @(negedge clk); op_s[0] = 2'b00;
    err_m[0] = 1'b1;
    chk("rsv_err", err_s[0], 1'b1);
    chk("rsv_busy", busy_s[0], 1'b0);
    chk("rsv_tx", tx_s[0], 1'b0);
    @(negedge clk);
    chk("rsv_busy2", busy_s[0], 1'b0);

    // Address errors complete their beats with zero data / dropped writes.
    do_txn(0, 1'b0, 32'h5000_0000, 1'b0);
    do_txn(0, 1'b0, 32'h2000_0004, 1'b0);
    do_txn(1, 1'b1, 32'h1000_0008, 1'b0);
    do_txn(1, 1'b0, 32'h1000_0000, 1'b0);
    do_txn(0, 1'b0, 32'h2000_0040, 1'b0);

    // Random mixed traffic.
    for (int t = 0; t < 24; t++) begin
      inst = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      rg   = int'($urandom_range(0, 3));
      if (rg == 1 && inst == 0 && $urandom_range(0, 3) != 0) rg = 2;
      ln   = int'($urandom_range(0, DEPTH - 1));
      addr = (32'(rg) << 28) | (32'(ln) << 6);
      if ($urandom_range(0, 7) == 0) addr[5:0] = 6'($urandom_range(1, 63));
      do_txn(inst, wr, addr, 1'b0);
    end

    // Reset in the middle of an accelerator write burst.
    @(negedge clk);
    op_s[0] = 2'b11; io_addr = 32'h1000_0000; wr_line = rand_line();
    seen = 0; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (c == 0) op_s[0] = 2'b00;
      if (tx_s[0]) begin
        seen++;
        if (seen == 5) begin rst = 1'b1; hit = 1'b1; end
      end else begin
        wr_line = rand_line();
      end
    end
    chk("rst_mid_reached", hit, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) chk_idle_zero(i, "rst_mid");
    do_txn(0, 1'b0, 32'h1000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_mem_bfm.md
Name: host_mem_bfm

Overview:
- Parametrised, cycle-accurate host-memory responder for proc-level benches; replaces hand-driven common_data_bus_in / tx_done / rd_valid stimulus.
- Watches the processor's op / io_addr / common_data_bus_out and serves single-line instr/data reads, single-line data writes, and multi-line accelerator bursts.
- Backed by per-region line memories.
- Adds configurable latency, burst length, inter-beat gap and error reporting.

Parameters:
LINE_W, 512, transfer line width in bits (multiple of 32)
DEPTH, 128, lines per region (power of 2)
REGIONS, 4, region count; region = io_addr[31:28] (0 instr, 1 accel, 2 data, 3 spare)
RD_LAT, 10, cycles from read accept to first tx_done
WR_LAT, 1, cycles from write accept to first tx_done
ACCEL_REGION, 1, region served as a burst
ACCEL_BURST, 128, lines per accelerator burst (1..DEPTH)
GAP, 0, idle cycles between burst beats

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op  in  2  request: 00 none, 01 read, 11 write, 10 reserved
io_addr  in  32  byte address; line index = io_addr[6 +: log2(DEPTH)]
wr_line  in  LINE_W  write data (proc common_data_bus_out)
rd_line  out  LINE_W  read data (proc common_data_bus_in)
tx_done  out  1  beat strobe
rd_valid  out  1  read-line-valid strobe
busy  out  1  transaction in progress
err  out  1  sticky error
beats_done  out  16  completed beats since reset, wraps at 2^16

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs 0; FSM to IDLE; err cleared; beat and wait counters cleared.
  - Every region loaded with ascending words: 32-bit word k of line n = n*(LINE_W/32)+k, word 0 in bits [31:0].
  - Reset mid-transaction abandons it; no partial write is committed.
- States: IDLE, RD_WAIT, RD_XFER, RD_VALID, WR_WAIT, WR_XFER, WR_GAP, BEAT_GAP.
- IDLE:
  - Sample op each posedge.
  - 01 -> latch region and line, beats = (region==ACCEL_REGION ? ACCEL_BURST : 1), go to RD_WAIT.
  - 11 -> same latch, go to WR_WAIT.
  - 10 -> set err, stay IDLE.
  - busy=0 only in IDLE.
- RD_WAIT:
  - Counts RD_LAT-1 cycles, so first tx_done is high exactly RD_LAT cycles after the accepting edge.
  - RD_LAT=1 goes directly to RD_XFER.
- RD_XFER (1 cycle): tx_done=1, rd_line = mem[region][line].
- RD_VALID (1 cycle):
  - rd_valid=1; rd_line held; beats_done++.
  - If beats remain: line=(line+1) mod DEPTH (wrap), then BEAT_GAP (GAP cycles; skipped if GAP=0) -> RD_XFER. Otherwise -> IDLE.
  - No new op is needed between beats.
- rd_line holds its last value when not in RD_XFER/RD_VALID.
- WR_WAIT: WR_LAT-1 cycles (WR_LAT=1 goes directly to WR_XFER).
- WR_XFER (1 cycle):
  - tx_done=1; wr_line sampled at the closing posedge into mem[region][line]; beats_done++.
  - -> WR_GAP (1 cycle, tx_done=0 so the proc can present the next line) -> WR_XFER for the next beat with line+1 mod DEPTH, else IDLE.
- Address error: region >= REGIONS or io_addr[5:0] != 0 sets err.
  - The transaction still completes its beat count (reads return all-zero lines, writes are dropped) so the processor never hangs.
- op changes while busy are ignored; op still asserted on return to IDLE is accepted as a new request that same edge.
- tx_done and rd_valid are never high in the same cycle.

Test Plan:
- Instr fetch: reset, op=01 with io_addr=0x0000_0000, RD_LAT=10 -> tx_done high exactly 10 cycles after accept, rd_line[31:0]=0 and [511:480]=15, rd_valid next cycle; beats_done=1, busy falls the following cycle.
- Data write then read: op=11 at 0x2000_0040 with wr_line words 0xA0..0xAF -> tx_done one cycle after accept, line 1 of region 2 updated; op=01 at the same address -> rd_line[31:0]=0xA0.
- Accel burst: op=01 at 0x1000_0000, GAP=0 -> 128 tx_done/rd_valid pairs on alternating cycles, beat j has rd_line[31:0]=16*j; beats_done=128, then IDLE.
- Accel write burst with wrap: op=11 at 0x1000_1FC0 (line 127), ACCEL_BURST=2 -> lines 127 then 0 written, 2 tx_done pulses separated by one low cycle.
- Errors: op=10 -> err=1, busy stays 0; op=01 at 0x5000_0000 -> err=1, one beat with rd_line=0; err clears only on rst.
- Reset mid-burst: rst asserted at beat 5 of an accel write -> all outputs 0 next cycle, memory back to the ascending pattern, next op=01 is served normally.
